// File: rtl/cva6_ptw_sv32_pkg.sv
// Shared Sv32 walker types: PTE layout, TLB update payload, walker states.
package cva6_ptw_sv32_pkg;

  localparam int unsigned SV32_PTESIZE = 4;
  localparam int unsigned PTE_OFF_W    = $clog2(SV32_PTESIZE);
  localparam int unsigned SV32_PPN_W   = 22;
  localparam int unsigned SV32_VPN_W   = 20;
  localparam int unsigned SV32_VPN0_W  = 10;
  localparam int unsigned SV32_PA_W    = SV32_PPN_W + SV32_VPN0_W + PTE_OFF_W;
  localparam int unsigned TLB_ASID_W   = 9;

  typedef struct packed {
    logic [SV32_PPN_W-1:0] ppn;
    logic [1:0]            rsw;
    logic                  d;
    logic                  a;
    logic                  g;
    logic                  u;
    logic                  x;
    logic                  w;
    logic                  r;
    logic                  v;
  } pte_sv32_t;

  typedef struct packed {
    logic                  valid;
    logic                  is_4M;
    logic [SV32_VPN_W-1:0] vpn;
    logic [TLB_ASID_W-1:0] asid;
    pte_sv32_t             content;
  } tlb_update_sv32_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID,
    DONE,
    FAULT,
    DRAIN
  } ptw_state_e;

  // A PTE with neither R nor X set points at the next table level
  function automatic logic pte_is_ptr(input pte_sv32_t pte);
    return !(pte.r || pte.x);
  endfunction

  function automatic logic [SV32_PA_W-1:0] pte_addr(input logic [SV32_PPN_W-1:0]  ppn,
                                                    input logic [SV32_VPN0_W-1:0] idx);
    return {ppn, idx, PTE_OFF_W'(0)};
  endfunction

endpackage

// File: rtl/cva6_ptw_sv32_pte_check.sv
// Combinational PTE classification: pointer vs. leaf, and page-fault detection.
module cva6_ptw_sv32_pte_check
  import cva6_ptw_sv32_pkg::*;
(
  input  pte_sv32_t pte,
  input  logic      lvl,
  input  logic      is_store,
  output logic      is_ptr_c,
  output logic      page_fault_c
);

  always_comb begin
    is_ptr_c     = pte_is_ptr(pte);
    page_fault_c = 1'b0;
    if (!pte.v || (!pte.r && pte.w)) begin
      page_fault_c = 1'b1;
    end else if (is_ptr_c) begin
      page_fault_c = !lvl;
    end else begin
      // superpage leaves must be 4 MiB aligned
      if (lvl && (pte.ppn[SV32_VPN0_W-1:0] != '0)) page_fault_c = 1'b1;
      if (!pte.a || (is_store && !pte.d))           page_fault_c = 1'b1;
    end
  end

endmodule

// File: rtl/cva6_ptw_sv32.sv
// Sv32 two-level page-table walker feeding the TLB update port.
module cva6_ptw_sv32
  import cva6_ptw_sv32_pkg::*;
#(
  parameter int unsigned ASID_WIDTH = 9,
  parameter int unsigned PLEN       = 34
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic [21:0]           satp_ppn_i,
  input  logic [ASID_WIDTH-1:0] asid_i,
  input  logic                  miss_valid_i,
  input  logic [31:0]           miss_vaddr_i,
  input  logic                  miss_is_store_i,
  output logic                  walking_o,
  output logic                  mem_req_o,
  output logic [PLEN-1:0]       mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  mem_err_i,
  output tlb_update_sv32_t      update_o,
  output logic                  page_fault_o,
  output logic                  access_fault_o,
  output logic [31:0]           fault_vaddr_o
);

  ptw_state_e            state_q;
  logic                  lvl_q;
  logic [31:0]           vaddr_q;
  logic [ASID_WIDTH-1:0] asid_q;
  logic                  is_store_q;
  tlb_update_sv32_t      upd_q;
  logic                  page_fault_q;
  logic                  access_fault_q;
  pte_sv32_t             pte;
  logic                  is_ptr_c;
  logic                  page_fault_c;

  assign pte = pte_sv32_t'(mem_rdata_i);

  cva6_ptw_sv32_pte_check i_pte_check (
    .pte          (pte),
    .lvl          (lvl_q),
    .is_store     (is_store_q),
    .is_ptr_c     (is_ptr_c),
    .page_fault_c (page_fault_c)
  );

  // A flush landing on the DONE/FAULT cycle masks the already-registered strobes
  always_comb begin
    update_o       = upd_q;
    update_o.valid = upd_q.valid & ~flush_i;
  end
  assign page_fault_o   = page_fault_q & ~flush_i;
  assign access_fault_o = access_fault_q & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      lvl_q          <= 1'b0;
      vaddr_q        <= '0;
      asid_q         <= '0;
      is_store_q     <= 1'b0;
      upd_q          <= '0;
      page_fault_q   <= 1'b0;
      access_fault_q <= 1'b0;
      walking_o      <= 1'b0;
      mem_req_o      <= 1'b0;
      mem_addr_o     <= '0;
      fault_vaddr_o  <= '0;
    end else begin
      upd_q.valid    <= 1'b0;
      page_fault_q   <= 1'b0;
      access_fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (miss_valid_i && !flush_i) begin
            vaddr_q    <= miss_vaddr_i;
            asid_q     <= asid_i;
            is_store_q <= miss_is_store_i;
            lvl_q      <= 1'b1;
            mem_addr_o <= PLEN'(pte_addr(satp_ppn_i, miss_vaddr_i[31:22]));
            mem_req_o  <= 1'b1;
            walking_o  <= 1'b1;
            state_q    <= WAIT_GNT;
          end
        end
        WAIT_GNT: begin
          if (mem_gnt_i) begin
            // an accepted request still owes a response, so a flush must drain it
            mem_req_o <= 1'b0;
            state_q   <= flush_i ? DRAIN : WAIT_RVALID;
          end else if (flush_i) begin
            mem_req_o <= 1'b0;
            walking_o <= 1'b0;
            state_q   <= IDLE;
          end
        end
        WAIT_RVALID: begin
          if (flush_i) begin
            if (mem_rvalid_i) begin
              walking_o <= 1'b0;
              state_q   <= IDLE;
            end else begin
              state_q <= DRAIN;
            end
          end else if (mem_rvalid_i) begin
            if (mem_err_i) begin
              access_fault_q <= 1'b1;
              fault_vaddr_o  <= vaddr_q;
              state_q        <= FAULT;
            end else if (page_fault_c) begin
              page_fault_q  <= 1'b1;
              fault_vaddr_o <= vaddr_q;
              state_q       <= FAULT;
            end else if (is_ptr_c) begin
              lvl_q      <= 1'b0;
              mem_addr_o <= PLEN'(pte_addr(pte.ppn, vaddr_q[21:12]));
              mem_req_o  <= 1'b1;
              state_q    <= WAIT_GNT;
            end else begin
              upd_q.valid   <= 1'b1;
              upd_q.is_4M   <= lvl_q;
              upd_q.vpn     <= vaddr_q[31:12];
              upd_q.asid    <= TLB_ASID_W'(asid_q);
              upd_q.content <= pte;
              state_q       <= DONE;
            end
          end
        end
        DONE, FAULT: begin
          walking_o <= 1'b0;
          state_q   <= IDLE;
        end
        DRAIN: begin
          if (mem_rvalid_i) begin
            walking_o <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          mem_req_o <= 1'b0;
          walking_o <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cva6_ptw_sv32.sv
// Directed bench for the Sv32 walker: vector table of full walks plus flush/stall/reset sequences.
module tb_cva6_ptw_sv32;
  import cva6_ptw_sv32_pkg::*;

  localparam int K_UPD = 0;
  localparam int K_PF  = 1;
  localparam int K_AF  = 2;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             flush_i = 1'b0;
  logic [21:0]      satp_ppn_i = '0;
  logic [8:0]       asid_i = '0;
  logic             miss_valid_i = 1'b0;
  logic [31:0]      miss_vaddr_i = '0;
  logic             miss_is_store_i = 1'b0;
  logic             walking_o;
  logic             mem_req_o;
  logic [33:0]      mem_addr_o;
  logic             mem_gnt_i = 1'b0;
  logic             mem_rvalid_i = 1'b0;
  logic [31:0]      mem_rdata_i = '0;
  logic             mem_err_i = 1'b0;
  tlb_update_sv32_t update_o;
  logic             page_fault_o;
  logic             access_fault_o;
  logic [31:0]      fault_vaddr_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk_i = ~clk_i;

  cva6_ptw_sv32 #(.ASID_WIDTH(9), .PLEN(34)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .flush_i         (flush_i),
    .satp_ppn_i      (satp_ppn_i),
    .asid_i          (asid_i),
    .miss_valid_i    (miss_valid_i),
    .miss_vaddr_i    (miss_vaddr_i),
    .miss_is_store_i (miss_is_store_i),
    .walking_o       (walking_o),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_gnt_i       (mem_gnt_i),
    .mem_rvalid_i    (mem_rvalid_i),
    .mem_rdata_i     (mem_rdata_i),
    .mem_err_i       (mem_err_i),
    .update_o        (update_o),
    .page_fault_o    (page_fault_o),
    .access_fault_o  (access_fault_o),
    .fault_vaddr_o   (fault_vaddr_o)
  );

  typedef struct {
    logic [21:0] satp;
    logic [31:0] vaddr;
    logic        store;
    logic [8:0]  asid;
    logic [31:0] l1_pte;
    logic        l1_err;
    logic [33:0] l1_addr;
    logic        two_lvl;
    logic [31:0] l0_pte;
    logic        l0_err;
    logic [33:0] l0_addr;
    int          kind;
    logic        is4m;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [21:0] satp, input logic [31:0] vaddr, input logic store,
                              input logic [8:0] asid, input logic [31:0] l1_pte, input logic l1_err,
                              input logic [33:0] l1_addr, input logic two_lvl, input logic [31:0] l0_pte,
                              input logic l0_err, input logic [33:0] l0_addr, input int kind,
                              input logic is4m);
    vec_t v;
    v.satp = satp; v.vaddr = vaddr; v.store = store; v.asid = asid;
    v.l1_pte = l1_pte; v.l1_err = l1_err; v.l1_addr = l1_addr; v.two_lvl = two_lvl;
    v.l0_pte = l0_pte; v.l0_err = l0_err; v.l0_addr = l0_addr; v.kind = kind; v.is4m = is4m;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " walking"}, 64'(walking_o), 64'd0);
    chk({tag, " req"},     64'(mem_req_o), 64'd0);
    chk({tag, " upd"},     64'(update_o.valid), 64'd0);
    chk({tag, " pf"},      64'(page_fault_o), 64'd0);
    chk({tag, " af"},      64'(access_fault_o), 64'd0);
  endtask

  task automatic issue_miss(input logic [21:0] satp, input logic [31:0] vaddr, input logic store);
    @(negedge clk_i);
    satp_ppn_i = satp; miss_vaddr_i = vaddr; miss_is_store_i = store; miss_valid_i = 1'b1;
    @(negedge clk_i);
    miss_valid_i = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data, input logic err);
    mem_rvalid_i = 1'b1; mem_rdata_i = data; mem_err_i = err;
    @(negedge clk_i);
    mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int i);
    string t;
    logic [31:0] leaf;
    t = $sformatf("v%0d", i);
    asid_i = v.asid;
    issue_miss(v.satp, v.vaddr, v.store);
    chk({t, " l1 req"},  64'(mem_req_o), 64'd1);
    chk({t, " l1 addr"}, 64'(mem_addr_o), 64'(v.l1_addr));
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    mem_gnt_i = 1'b0;
    chk({t, " req drop"}, 64'(mem_req_o), 64'd0);
    respond(v.l1_pte, v.l1_err);
    if (v.two_lvl) begin
      chk({t, " l0 req"},  64'(mem_req_o), 64'd1);
      chk({t, " l0 addr"}, 64'(mem_addr_o), 64'(v.l0_addr));
      mem_gnt_i = 1'b1;
      @(negedge clk_i);
      mem_gnt_i = 1'b0;
      respond(v.l0_pte, v.l0_err);
    end
    leaf = v.two_lvl ? v.l0_pte : v.l1_pte;
    chk({t, " walking"}, 64'(walking_o), 64'd1);
    chk({t, " upd"}, 64'(update_o.valid), 64'(v.kind == K_UPD));
    chk({t, " pf"},  64'(page_fault_o),   64'(v.kind == K_PF));
    chk({t, " af"},  64'(access_fault_o), 64'(v.kind == K_AF));
    if (v.kind == K_UPD) begin
      chk({t, " is4M"},    64'(update_o.is_4M), 64'(v.is4m));
      chk({t, " vpn"},     64'(update_o.vpn), 64'(v.vaddr[31:12]));
      chk({t, " asid"},    64'(update_o.asid), 64'(v.asid));
      chk({t, " content"}, 64'(update_o.content), 64'(leaf));
    end else begin
      chk({t, " fvaddr"}, 64'(fault_vaddr_o), 64'(v.vaddr));
    end
    @(negedge clk_i);
    check_idle({t, " after"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(22'h00080, 32'h40001234, 1'b0, 9'h005, 32'h20000401, 1'b0, 34'h000080400, 1'b1,
                  32'h200000CF, 1'b0, 34'h080001004, K_UPD, 1'b0);
    vecs[1]  = mk(22'h00080, 32'h80400000, 1'b0, 9'h1AB, 32'h200000CF, 1'b0, 34'h000080804, 1'b0,
                  32'h0, 1'b0, 34'h0, K_UPD, 1'b1);
    vecs[2]  = mk(22'h00080, 32'h80400000, 1'b0, 9'h002, 32'h200004CF, 1'b0, 34'h000080804, 1'b0,
                  32'h0, 1'b0, 34'h0, K_PF, 1'b0);
    vecs[3]  = mk(22'h00080, 32'h80400000, 1'b1, 9'h003, 32'h2000004F, 1'b0, 34'h000080804, 1'b0,
                  32'h0, 1'b0, 34'h0, K_PF, 1'b0);
    vecs[4]  = mk(22'h00080, 32'h40001234, 1'b0, 9'h004, 32'h20000401, 1'b0, 34'h000080400, 1'b1,
                  32'h200000CF, 1'b1, 34'h080001004, K_AF, 1'b0);
    vecs[5]  = mk(22'h3FFFFF, 32'hFFC00000, 1'b0, 9'h0FF, 32'h00000000, 1'b0, 34'h3FFFFFFFC, 1'b0,
                  32'h0, 1'b0, 34'h0, K_PF, 1'b0);
    vecs[6]  = mk(22'h00080, 32'h40001234, 1'b0, 9'h006, 32'h20000401, 1'b0, 34'h000080400, 1'b1,
                  32'h20000401, 1'b0, 34'h080001004, K_PF, 1'b0);
    vecs[7]  = mk(22'h00080, 32'h80400000, 1'b0, 9'h007, 32'h200000C5, 1'b0, 34'h000080804, 1'b0,
                  32'h0, 1'b0, 34'h0, K_PF, 1'b0);
    vecs[8]  = mk(22'h00080, 32'h40001234, 1'b0, 9'h008, 32'h20000401, 1'b0, 34'h000080400, 1'b1,
                  32'h2000008F, 1'b0, 34'h080001004, K_PF, 1'b0);
    vecs[9]  = mk(22'h00080, 32'h40001234, 1'b0, 9'h009, 32'h20000401, 1'b0, 34'h000080400, 1'b1,
                  32'h2000004F, 1'b0, 34'h080001004, K_UPD, 1'b0);
    vecs[10] = mk(22'h00080, 32'h80400000, 1'b0, 9'h00A, 32'h200000CF, 1'b1, 34'h000080804, 1'b0,
                  32'h0, 1'b0, 34'h0, K_AF, 1'b0);
    vecs[11] = mk(22'h12345, 32'h003FF000, 1'b0, 9'h100, 32'hFFFFFC01, 1'b0, 34'h012345000, 1'b1,
                  32'hFFFFFCCF, 1'b0, 34'h3FFFFFFFC, K_UPD, 1'b0);
    vecs[12] = mk(22'h00080, 32'h80400000, 1'b1, 9'h00C, 32'h200000CF, 1'b0, 34'h000080804, 1'b0,
                  32'h0, 1'b0, 34'h0, K_UPD, 1'b1);

    // reset state
    repeat (2) @(negedge clk_i);
    check_idle("reset");
    chk("reset addr", 64'(mem_addr_o), 64'd0);
    chk("reset upd word", 64'(update_o), 64'd0);
    chk("reset fvaddr", 64'(fault_vaddr_o), 64'd0);
    rst_ni = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // miss and flush together in IDLE: flush wins
    @(negedge clk_i);
    satp_ppn_i = 22'h00080; miss_vaddr_i = 32'h40001234; miss_valid_i = 1'b1; flush_i = 1'b1;
    @(negedge clk_i);
    miss_valid_i = 1'b0; flush_i = 1'b0;
    check_idle("idle flush");

    // flush in WAIT_GNT without grant
    issue_miss(22'h00080, 32'h40001234, 1'b0);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check_idle("gnt flush");

    // flush in WAIT_RVALID, drain a late response, then accept a new miss
    issue_miss(22'h00080, 32'h40001234, 1'b0);
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    mem_gnt_i = 1'b0;
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    chk("drain walking", 64'(walking_o), 64'd1);
    chk("drain req", 64'(mem_req_o), 64'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("drain hold", 64'(walking_o), 64'd1);
    respond(32'h200000CF, 1'b0);
    check_idle("drain done");
    issue_miss(22'h00080, 32'h80400000, 1'b0);
    chk("post drain req", 64'(mem_req_o), 64'd1);
    chk("post drain addr", 64'(mem_addr_o), 64'h080804);
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    mem_gnt_i = 1'b0;
    respond(32'h200000CF, 1'b0);
    chk("post drain upd", 64'(update_o.valid), 64'd1);
    chk("post drain vpn", 64'(update_o.vpn), 64'h80400);
    @(negedge clk_i);

    // flush on the DONE / FAULT cycle masks the strobe
    for (int k = 0; k < 2; k++) begin
      issue_miss(22'h00080, 32'h80400000, 1'b0);
      mem_gnt_i = 1'b1;
      @(negedge clk_i);
      mem_gnt_i = 1'b0;
      respond((k == 0) ? 32'h200000CF : 32'h200004CF, 1'b0);
      flush_i = 1'b1;
      #1;
      chk($sformatf("flush mask upd %0d", k), 64'(update_o.valid), 64'd0);
      chk($sformatf("flush mask pf %0d", k), 64'(page_fault_o), 64'd0);
      @(negedge clk_i);
      flush_i = 1'b0;
      check_idle($sformatf("flush mask after %0d", k));
    end

    // grant stalled five cycles: address must hold; then async reset mid-walk
    issue_miss(22'h00080, 32'h40001234, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall req %0d", k), 64'(mem_req_o), 64'd1);
      chk($sformatf("stall addr %0d", k), 64'(mem_addr_o), 64'h080400);
      @(negedge clk_i);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    check_idle("async rst");
    chk("async rst addr", 64'(mem_addr_o), 64'd0);
    chk("async rst fvaddr", 64'(fault_vaddr_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_idle("post rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
